// File: rtl/mandel_pkg.sv
// Shared types and default geometry for the Mandelbrot engine array.
// Holds the frame-scheduler state encoding, the render configuration
// record and the screen/iteration defaults used by engine_dispatcher.
package mandel_pkg;

   localparam int PIXEL_DATA_WIDTH = 10;
   localparam int ITERATIONS_WIDTH = 6;
   localparam int X_PIXELS         = 640;
   localparam int Y_PIXELS         = 480;
   localparam int ZOOM_WIDTH       = 3;
   localparam int OFFSET_WIDTH     = 25;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      DRAIN,
      DONE
   } dispatch_state_t;

   typedef struct packed {
      logic [ITERATIONS_WIDTH-1:0] iterations_max;
      logic [ZOOM_WIDTH-1:0]       zoom;
      logic [OFFSET_WIDTH-1:0]     x_offset;
      logic [OFFSET_WIDTH-1:0]     y_offset;
   } cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Picks the lowest requesting index at or above ptr, wrapping past N-1
// back to 0, and reports it both one-hot and as a binary index.
module rr_arbiter #(
   parameter int N         = 8,
   parameter int PTR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]         req,
   input  logic [PTR_WIDTH-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [PTR_WIDTH-1:0] index,
   output logic                 any
);

   logic [PTR_WIDTH:0] cand;

   // Scan the requesters starting at ptr and walking upward with
   // wrap-around; the first requester met is the winner, so lower
   // indices just behind the pointer get their turn on the next lap.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (PTR_WIDTH+1)'(i);
         if (cand >= (PTR_WIDTH+1)'(N)) begin
            cand = cand - (PTR_WIDTH+1)'(N);
         end
         if (!any && req[cand[PTR_WIDTH-1:0]]) begin
            any   = 1'b1;
            index = cand[PTR_WIDTH-1:0];
         end
      end
      if (any) begin
         grant[index] = 1'b1;
      end
   end

endmodule

// File: rtl/engine_dispatcher.sv
// Frame-level scheduler for the Mandelbrot engine array.
// Walks the screen in raster order, handing one pixel per cycle to an
// idle engine chosen round-robin, latches the render configuration at
// frame start and pulses frame_done once every issued pixel is retired.
// Optional build macro DISPATCH_STATS_EN adds frame_cycles and
// grant_count statistics outputs.
module engine_dispatcher
#(
   parameter int NUM_ENGINES      = 8,
   parameter int PIXEL_DATA_WIDTH = mandel_pkg::PIXEL_DATA_WIDTH,
   parameter int ITERATIONS_WIDTH = mandel_pkg::ITERATIONS_WIDTH,
   parameter int X_PIXELS         = mandel_pkg::X_PIXELS,
   parameter int Y_PIXELS         = mandel_pkg::Y_PIXELS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                abort,
   input  logic [ITERATIONS_WIDTH-1:0]         iterations_max_i,
   input  logic [mandel_pkg::ZOOM_WIDTH-1:0]   zoom_i,
   input  logic [mandel_pkg::OFFSET_WIDTH-1:0] x_offset_i,
   input  logic [mandel_pkg::OFFSET_WIDTH-1:0] y_offset_i,
   input  logic [NUM_ENGINES-1:0]              engine_ready,
   output logic [NUM_ENGINES-1:0]              dispatch_valid,
   output logic [PIXEL_DATA_WIDTH-1:0]         dispatch_x,
   output logic [PIXEL_DATA_WIDTH-1:0]         dispatch_y,
   output logic [ITERATIONS_WIDTH-1:0]         iterations_max_o,
   output logic [mandel_pkg::ZOOM_WIDTH-1:0]   zoom_o,
   output logic [mandel_pkg::OFFSET_WIDTH-1:0] x_offset_o,
   output logic [mandel_pkg::OFFSET_WIDTH-1:0] y_offset_o,
   output logic                                busy,
   output logic                                frame_done
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]                         frame_cycles,
   output logic [NUM_ENGINES*20-1:0]           grant_count
`endif
);

   import mandel_pkg::*;

   localparam int PTR_WIDTH = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam logic [PTR_WIDTH-1:0]        LAST_ENGINE = PTR_WIDTH'(NUM_ENGINES - 1);
   localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST      = PIXEL_DATA_WIDTH'(X_PIXELS - 1);
   localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST      = PIXEL_DATA_WIDTH'(Y_PIXELS - 1);

   dispatch_state_t               state;
   dispatch_state_t               nextState;
   logic [PIXEL_DATA_WIDTH-1:0]   xCount;
   logic [PIXEL_DATA_WIDTH-1:0]   yCount;
   logic [PTR_WIDTH-1:0]          rrPtr;
   logic [NUM_ENGINES-1:0]        holdMask;
   logic [NUM_ENGINES-1:0]        eligible;
   logic [NUM_ENGINES-1:0]        arbGrant;
   logic [PTR_WIDTH-1:0]          arbIndex;
   logic                          arbAny;
   logic                          grantFire;
   logic                          lastPixel;
   logic                          acceptStart;

   assign eligible   = engine_ready & ~holdMask;
   assign lastPixel  = (xCount == X_LAST) && (yCount == Y_LAST);
   assign dispatch_x = xCount;
   assign dispatch_y = yCount;

   rr_arbiter #(
      .N         (NUM_ENGINES),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_arbiter (
      .req   (eligible),
      .ptr   (rrPtr),
      .grant (arbGrant),
      .index (arbIndex),
      .any   (arbAny)
   );

   // Frame state register; reset drops any frame in flight back to IDLE
   // without producing a frame_done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and strobe decode. A grant only fires in DISPATCH when no
   // abort is present this cycle, so abort always beats a pending grant.
   // DRAIN waits until every engine reports ready and no engine is still
   // inside its post-strobe hold window before declaring the frame retired.
   always_comb begin
      nextState      = state;
      grantFire      = 1'b0;
      acceptStart    = 1'b0;
      dispatch_valid = '0;
      busy           = 1'b0;
      frame_done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               acceptStart = 1'b1;
               nextState   = DISPATCH;
            end
         end
         DISPATCH: begin
            busy = 1'b1;
            if (abort) begin
               nextState = DRAIN;
            end else if (arbAny) begin
               grantFire      = 1'b1;
               dispatch_valid = arbGrant;
               if (lastPixel) begin
                  nextState = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if ((&engine_ready) && (holdMask == '0)) begin
               nextState = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            nextState  = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Raster counters, round-robin pointer, hold mask and configuration
   // latch. An engine's ready only falls one cycle after its strobe, so
   // the granted engine is masked for exactly the following cycle to stop
   // a double issue. The final pixel leaves DISPATCH, where nothing can be
   // re-granted, so its hold is not loaded and an idle array retires the
   // frame with a single DRAIN cycle followed by DONE. The configuration
   // only moves on an accepted start so engines in flight see stable data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xCount           <= '0;
         yCount           <= '0;
         rrPtr            <= '0;
         holdMask         <= '0;
         iterations_max_o <= '0;
         zoom_o           <= '0;
         x_offset_o       <= '0;
         y_offset_o       <= '0;
      end else begin
         if (acceptStart) begin
            xCount           <= '0;
            yCount           <= '0;
            iterations_max_o <= iterations_max_i;
            zoom_o           <= zoom_i;
            x_offset_o       <= x_offset_i;
            y_offset_o       <= y_offset_i;
         end else if (grantFire) begin
            if (xCount == X_LAST) begin
               xCount <= '0;
               yCount <= lastPixel ? '0 : yCount + PIXEL_DATA_WIDTH'(1);
            end else begin
               xCount <= xCount + PIXEL_DATA_WIDTH'(1);
            end
         end
         holdMask <= (grantFire && !lastPixel) ? arbGrant : '0;
         if (grantFire) begin
            rrPtr <= (arbIndex == LAST_ENGINE) ? '0 : arbIndex + PTR_WIDTH'(1);
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [31:0]                  frameCycles;
   logic [NUM_ENGINES-1:0][19:0] grantTotals;

   assign frame_cycles = frameCycles;
   assign grant_count  = grantTotals;

   // Frame statistics: the cycle count covers the start cycle through the
   // DONE cycle and saturates; per-engine grant totals restart on every
   // accepted start and then hold the last frame's figures while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frameCycles <= '0;
         grantTotals <= '0;
      end else if (acceptStart) begin
         frameCycles <= 32'd1;
         grantTotals <= '0;
      end else if (state != IDLE) begin
         if (frameCycles != '1) begin
            frameCycles <= frameCycles + 32'd1;
         end
         if (grantFire) begin
            grantTotals[arbIndex] <= grantTotals[arbIndex] + 20'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_engine_dispatcher.sv
// Directed self-checking bench for engine_dispatcher on a 4x2 screen with
// four engines: raster order, single-engine throttling, drain wait,
// configuration latch, abort, ignored start and asynchronous reset.
module tb_engine_dispatcher;

   localparam int NE = 4;
   localparam int XP = 4;
   localparam int YP = 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic [5:0]    iterations_max_i;
   logic [2:0]    zoom_i;
   logic [24:0]   x_offset_i;
   logic [24:0]   y_offset_i;
   logic [NE-1:0] engine_ready;
   logic [NE-1:0] dispatch_valid;
   logic [9:0]    dispatch_x;
   logic [9:0]    dispatch_y;
   logic [5:0]    iterations_max_o;
   logic [2:0]    zoom_o;
   logic [24:0]   x_offset_o;
   logic [24:0]   y_offset_o;
   logic          busy;
   logic          frame_done;

   int checkCount;
   int errorCount;

   engine_dispatcher #(
      .NUM_ENGINES (NE),
      .X_PIXELS    (XP),
      .Y_PIXELS    (YP)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .iterations_max_i (iterations_max_i),
      .zoom_i           (zoom_i),
      .x_offset_i       (x_offset_i),
      .y_offset_i       (y_offset_i),
      .engine_ready     (engine_ready),
      .dispatch_valid   (dispatch_valid),
      .dispatch_x       (dispatch_x),
      .dispatch_y       (dispatch_y),
      .iterations_max_o (iterations_max_o),
      .zoom_o           (zoom_o),
      .x_offset_o       (x_offset_o),
      .y_offset_o       (y_offset_o),
      .busy             (busy),
      .frame_done       (frame_done)
   );

   // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive control inputs on the falling edge and settle before sampling.
   task automatic applyStimulus(input logic startVal, input logic abortVal,
                                input logic [NE-1:0] readyVal);
      @(negedge clk);
      start        = startVal;
      abort        = abortVal;
      engine_ready = readyVal;
      #1;
   endtask

   // Single comparison point with failure accounting.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // A cycle carrying a strobe to one engine with the given coordinate.
   task automatic expectStrobe(input string tag, input int engine,
                               input int xVal, input int yVal);
      checkOutput({tag, "_valid"}, 32'(dispatch_valid), 32'(1) << engine);
      checkOutput({tag, "_x"}, 32'(dispatch_x), 32'(xVal));
      checkOutput({tag, "_y"}, 32'(dispatch_y), 32'(yVal));
   endtask

   initial begin
      checkCount       = 0;
      errorCount       = 0;
      reset            = 1'b0;
      start            = 1'b0;
      abort            = 1'b0;
      engine_ready     = '0;
      iterations_max_i = '0;
      zoom_i           = '0;
      x_offset_i       = '0;
      y_offset_i       = '0;

      // Reset values
      #1;
      checkOutput("rst_valid", 32'(dispatch_valid), 32'h0);
      checkOutput("rst_x", 32'(dispatch_x), 32'h0);
      checkOutput("rst_y", 32'(dispatch_y), 32'h0);
      checkOutput("rst_iter", 32'(iterations_max_o), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(frame_done), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Raster order with every engine ready, config change mid-frame
      iterations_max_i = 6'd63;
      zoom_i           = 3'd5;
      x_offset_i       = 25'h123456;
      y_offset_i       = 25'h0ABCDE;
      applyStimulus(1'b1, 1'b0, 4'b1111);
      checkOutput("idle_busy", 32'(busy), 32'h0);
      checkOutput("idle_valid", 32'(dispatch_valid), 32'h0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b0, 4'b1111);
         if (k == 0) begin
            iterations_max_i = 6'd5;
         end
         expectStrobe("raster", k % 4, k % 4, k / 4);
         checkOutput("raster_busy", 32'(busy), 32'h1);
         checkOutput("raster_iter", 32'(iterations_max_o), 32'd63);
      end
      checkOutput("raster_zoom", 32'(zoom_o), 32'd5);
      checkOutput("raster_xoff", 32'(x_offset_o), 32'h123456);
      checkOutput("raster_yoff", 32'(y_offset_o), 32'h0ABCDE);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("raster_drain_valid", 32'(dispatch_valid), 32'h0);
      checkOutput("raster_drain_done", 32'(frame_done), 32'h0);
      checkOutput("raster_drain_busy", 32'(busy), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("raster_done", 32'(frame_done), 32'h1);
      checkOutput("raster_done_busy", 32'(busy), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("raster_done_pulse", 32'(frame_done), 32'h0);

      // Single idle engine: engine 2 every other cycle, then a drain wait
      applyStimulus(1'b1, 1'b0, 4'b0100);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b0, 4'b0100);
         expectStrobe("single", 2, k % 4, k / 4);
         if (k < 7) begin
            applyStimulus(1'b0, 1'b0, 4'b0100);
            checkOutput("single_hold_valid", 32'(dispatch_valid), 32'h0);
         end
      end
      checkOutput("single_iter", 32'(iterations_max_o), 32'd5);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 1'b0, 4'b1101);
         checkOutput("drain_busy", 32'(busy), 32'h1);
         checkOutput("drain_done", 32'(frame_done), 32'h0);
      end
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("drain_ret_done", 32'(frame_done), 32'h0);
      checkOutput("drain_ret_busy", 32'(busy), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("drain_fin_done", 32'(frame_done), 32'h1);
      checkOutput("drain_fin_busy", 32'(busy), 32'h0);

      // Abort after three grants; pointer resumes at engine 3
      applyStimulus(1'b1, 1'b0, 4'b1111);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      expectStrobe("abort_g0", 3, 0, 0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      expectStrobe("abort_g1", 0, 1, 0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      expectStrobe("abort_g2", 1, 2, 0);
      applyStimulus(1'b0, 1'b1, 4'b1111);
      checkOutput("abort_no_grant", 32'(dispatch_valid), 32'h0);
      checkOutput("abort_busy", 32'(busy), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("abort_drain_done", 32'(frame_done), 32'h0);
      checkOutput("abort_drain_busy", 32'(busy), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("abort_done", 32'(frame_done), 32'h1);

      // Next frame restarts at (0,0) on the engine after the last grant
      applyStimulus(1'b1, 1'b0, 4'b1111);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      expectStrobe("resume_g0", 2, 0, 0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      expectStrobe("resume_g1", 3, 1, 0);

      // Asynchronous reset mid-frame
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(dispatch_valid), 32'h0);
      checkOutput("mid_rst_x", 32'(dispatch_x), 32'h0);
      checkOutput("mid_rst_y", 32'(dispatch_y), 32'h0);
      checkOutput("mid_rst_iter", 32'(iterations_max_o), 32'h0);
      checkOutput("mid_rst_zoom", 32'(zoom_o), 32'h0);
      checkOutput("mid_rst_xoff", 32'(x_offset_o), 32'h0);
      checkOutput("mid_rst_yoff", 32'(y_offset_o), 32'h0);
      checkOutput("mid_rst_busy", 32'(busy), 32'h0);
      checkOutput("mid_rst_done", 32'(frame_done), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("rst_hold_done", 32'(frame_done), 32'h0);
      checkOutput("rst_hold_valid", 32'(dispatch_valid), 32'h0);
      reset = 1'b1;

      // Normal frame after reset, with a start ignored mid-frame
      iterations_max_i = 6'd7;
      zoom_i           = 3'd2;
      applyStimulus(1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(k == 2, 1'b0, 4'b1111);
         if (k == 2) begin
            iterations_max_i = 6'd9;
            zoom_i           = 3'd6;
         end
         expectStrobe("post_rst", k % 4, k % 4, k / 4);
         checkOutput("post_rst_iter", 32'(iterations_max_o), 32'd7);
      end
      checkOutput("post_rst_zoom", 32'(zoom_o), 32'd2);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("post_rst_drain", 32'(frame_done), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("post_rst_done", 32'(frame_done), 32'h1);
      checkOutput("post_rst_idle_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
